// File: rtl/pc_if.sv
// Fetch-side bus between the next-PC logic (master) and the program-counter unit (slave).
interface pc_if #(
  parameter int XLEN = 32
);
  logic            stall;
  logic            fetch_ready;
  logic            redirect;
  logic [XLEN-1:0] redirect_target;
  logic            trap_req;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus_inc;
  logic            pc_valid;
  logic [XLEN-1:0] epc;
  logic [XLEN-1:0] bad_addr;
  logic            trap_taken;

  modport master (
    output stall, fetch_ready, redirect, redirect_target, trap_req,
    input  pc, pc_plus_inc, pc_valid, epc, bad_addr, trap_taken
  );

  modport slave (
    input  stall, fetch_ready, redirect, redirect_target, trap_req,
    output pc, pc_plus_inc, pc_valid, epc, bad_addr, trap_taken
  );
endinterface

// File: rtl/pc_unit.sv
// Program-counter unit: sequential advance, redirect, trap entry with a one-cycle
// bubble, a post-reset boot bubble, and misaligned-redirect trapping.
//
// state          | meaning
// ST_BOOT        | first cycle after reset release, pc not yet valid
// ST_RUN         | normal fetch, pc valid, advances when not stalled/back-pressured
// ST_TRAP_BUBBLE | one cycle after a trap, pc parked at TRAP_VECTOR, not valid
module pc_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int              INC          = 4
) (
  input  logic  clk,
  input  logic  reset,
  pc_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_BOOT        = 2'd0,
    ST_RUN         = 2'd1,
    ST_TRAP_BUBBLE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] bad_q, bad_d;
  logic            trap_q, trap_d;
  logic [XLEN-1:0] pc_inc;
  logic            advance;
  logic            misaligned;

  assign pc_inc     = pc_q + XLEN'(INC);
  assign advance    = (state_q == ST_RUN) && !bus.stall && bus.fetch_ready;
  assign misaligned = bus.redirect && (bus.redirect_target[1:0] != 2'b00);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_VECTOR;
      epc_q   <= '0;
      bad_q   <= '0;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      bad_q   <= bad_d;
      trap_q  <= trap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    bad_d   = bad_q;
    trap_d  = 1'b0;
    case (state_q)
      ST_BOOT:        state_d = ST_RUN;
      ST_TRAP_BUBBLE: state_d = ST_RUN;
      ST_RUN: begin
        if (advance) begin
          if (bus.trap_req || misaligned) begin
            // trap_req outranks a simultaneous redirect, so bad_addr is only
            // loaded when the misaligned redirect itself caused the trap
            pc_d    = TRAP_VECTOR;
            epc_d   = pc_q;
            bad_d   = bus.trap_req ? '0 : bus.redirect_target;
            trap_d  = 1'b1;
            state_d = ST_TRAP_BUBBLE;
          end else if (bus.redirect) begin
            pc_d = bus.redirect_target;
          end else begin
            pc_d = pc_inc;
          end
        end
      end
      default:        state_d = ST_BOOT;
    endcase
  end

  assign bus.pc          = pc_q;
  assign bus.pc_plus_inc = pc_inc;
  assign bus.pc_valid    = (state_q == ST_RUN);
  assign bus.epc         = epc_q;
  assign bus.bad_addr    = bad_q;
  assign bus.trap_taken  = trap_q;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: a behavioural model predicts each edge, the
// prediction is queued before the edge and compared against the DUT after it.
module tb_pc_unit;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0100;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] epc;
    logic [31:0] bad;
    logic        valid;
    logic        trap;
  } exp_t;

  logic clk;
  logic reset;
  pc_if #(.XLEN(32)) bus ();

  pc_unit #(
    .XLEN(32), .RESET_VECTOR(RV), .TRAP_VECTOR(TV), .INC(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_compared   = 0;
  int n_mismatched = 0;
  exp_t sb_q[$];

  // model state: 0 boot, 1 run, 2 trap bubble
  int          m_state;
  logic [31:0] m_pc, m_epc, m_bad;
  logic        m_trap;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_compared++;
    if (obs !== expv) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_pc    = RV;
    m_epc   = '0;
    m_bad   = '0;
    m_trap  = 1'b0;
  endtask

  // Predict the next edge from current inputs, queue it, clock, then compare.
  task automatic step(input string tag);
    exp_t e;
    bit   adv;
    exp_t got;
    adv    = (m_state == 1) && !bus.stall && bus.fetch_ready;
    m_trap = 1'b0;
    if (m_state != 1) begin
      m_state = 1;
    end else if (adv) begin
      if (bus.trap_req) begin
        m_epc = m_pc; m_pc = TV; m_bad = '0; m_trap = 1'b1; m_state = 2;
      end else if (bus.redirect && bus.redirect_target[1:0] != 2'b00) begin
        m_epc = m_pc; m_pc = TV; m_bad = bus.redirect_target; m_trap = 1'b1; m_state = 2;
      end else if (bus.redirect) begin
        m_pc = bus.redirect_target;
      end else begin
        m_pc = m_pc + 32'd4;
      end
    end
    e.pc = m_pc; e.epc = m_epc; e.bad = m_bad; e.valid = (m_state == 1); e.trap = m_trap;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      got = sb_q.pop_front();
      check({tag, "_pc"},       bus.pc,                 got.pc);
      check({tag, "_valid"},    {31'd0, bus.pc_valid},  {31'd0, got.valid});
      check({tag, "_epc"},      bus.epc,                got.epc);
      check({tag, "_bad"},      bus.bad_addr,           got.bad);
      check({tag, "_trap"},     {31'd0, bus.trap_taken}, {31'd0, got.trap});
      check({tag, "_plus_inc"}, bus.pc_plus_inc,        got.pc + 32'd4);
    end
  endtask

  task automatic set_in(input logic st, input logic fr, input logic rd,
                        input logic [31:0] tgt, input logic tr);
    bus.stall           = st;
    bus.fetch_ready     = fr;
    bus.redirect        = rd;
    bus.redirect_target = tgt;
    bus.trap_req        = tr;
  endtask

  initial begin
    set_in(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    reset = 1'b0;
    model_reset();
    #12;
    check("rst_pc",    bus.pc,                   RV);
    check("rst_valid", {31'd0, bus.pc_valid},    32'd0);
    check("rst_epc",   bus.epc,                  32'd0);
    check("rst_bad",   bus.bad_addr,             32'd0);
    check("rst_trap",  {31'd0, bus.trap_taken},  32'd0);
    reset = 1'b1;

    // boot bubble then sequential 0,4,8,12,16
    step("boot");
    check("boot_pc_fixed", bus.pc, 32'h0);
    for (int i = 0; i < 4; i++) step("seq");
    check("seq_pc_fixed", bus.pc, 32'h10);

    // stall with redirect held: ignored, then taken
    set_in(1'b1, 1'b1, 1'b1, 32'h40, 1'b0);
    for (int i = 0; i < 3; i++) step("stall");
    check("stall_pc_fixed", bus.pc, 32'h10);
    set_in(1'b0, 1'b1, 1'b1, 32'h40, 1'b0);
    step("redir40");
    check("redir_pc_fixed", bus.pc, 32'h40);

    // misaligned redirect at pc=0x20
    set_in(1'b0, 1'b1, 1'b1, 32'h20, 1'b0);
    step("to20");
    set_in(1'b0, 1'b1, 1'b1, 32'h202, 1'b0);
    step("mis");
    check("mis_pc_fixed",  bus.pc,       32'h100);
    check("mis_epc_fixed", bus.epc,      32'h20);
    check("mis_bad_fixed", bus.bad_addr, 32'h202);
    set_in(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    step("bubble");
    step("after_bubble");
    check("bubble_pc_fixed", bus.pc, 32'h104);

    // trap beats redirect at pc=0x30
    set_in(1'b0, 1'b1, 1'b1, 32'h30, 1'b0);
    step("to30");
    set_in(1'b0, 1'b1, 1'b1, 32'h80, 1'b1);
    step("trap");
    check("trap_epc_fixed", bus.epc,      32'h30);
    check("trap_bad_fixed", bus.bad_addr, 32'h0);
    set_in(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    step("bubble2");

    // wrap at top of address space, then back-pressure
    set_in(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
    step("tofffc");
    set_in(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    step("wrap");
    check("wrap_pc_fixed", bus.pc, 32'h0);
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step("bp");
    step("bp");
    set_in(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    step("post_bp");
    step("post_bp");

    // asynchronous reset between edges
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check("async_pc",    bus.pc,                 RV);
    check("async_valid", {31'd0, bus.pc_valid},  32'd0);
    check("async_trap",  {31'd0, bus.trap_taken}, 32'd0);
    #2;
    reset = 1'b1;
    step("reboot");
    step("reseq");
    step("reseq");
    check("reseq_pc_fixed", bus.pc, 32'h8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised program-counter unit that replaces the plain PC register in the RV32I datapath. It holds the fetch address and advances it sequentially, on a redirect, or on a trap. It supports stall and instruction-memory back-pressure, a post-reset boot bubble, and detection of misaligned redirect targets with exception-PC capture. It sits between the next-PC logic (branch/jump resolution) and the instruction memory address port.

Parameters:
XLEN, 32, PC and address width in bits
RESET_VECTOR, 32'h0000_0000, value loaded into pc on reset (XLEN bits)
TRAP_VECTOR, 32'h0000_0100, value loaded into pc on any trap (XLEN bits)
INC, 4, sequential increment in bytes

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset
stall  input  1  hold request from hazard or control logic
fetch_ready  input  1  instruction memory can accept the current pc
redirect  input  1  take redirect_target instead of pc+INC
redirect_target  input  XLEN  branch or jump target
trap_req  input  1  synchronous exception request (ecall/ebreak/illegal)
pc  output  XLEN  current fetch address
pc_plus_inc  output  XLEN  pc+INC, combinational, modulo 2^XLEN
pc_valid  output  1  pc is a valid fetch address this cycle
epc  output  XLEN  pc of the instruction that trapped
bad_addr  output  XLEN  offending target on a misaligned trap, else 0 on that trap
trap_taken  output  1  one-cycle pulse, registered, when a trap is taken

Behaviour:
- Reset (reset=0, async, takes effect immediately mid-operation):
  - pc=RESET_VECTOR, epc=0, bad_addr=0, trap_taken=0, pc_valid=0.
  - State goes to BOOT.
- States:
  - BOOT: lasts exactly one clock after reset release. pc holds; pc_valid=0. Next state is RUN.
  - RUN: pc_valid=1.
  - TRAP_BUBBLE: lasts one cycle. pc holds at TRAP_VECTOR; pc_valid=0. Next state is RUN.
- advance = (state==RUN) & ~stall & fetch_ready.
- When advance=0:
  - pc, epc and bad_addr hold.
  - redirect and trap_req are ignored, and the requester must hold them until advance=1.
  - trap_taken=0.
- When advance=1, priority is highest first:
  1. trap_req=1: pc<=TRAP_VECTOR, epc<=pc, bad_addr<=0, trap_taken<=1, state<=TRAP_BUBBLE.
  2. redirect=1 with redirect_target[1:0]!=0 (misaligned): pc<=TRAP_VECTOR, epc<=pc, bad_addr<=redirect_target, trap_taken<=1, state<=TRAP_BUBBLE.
  3. redirect=1, aligned: pc<=redirect_target.
  4. Otherwise: pc<=pc+INC, wrapping modulo 2^XLEN (e.g. 32'hFFFF_FFFC -> 0).
- trap_taken is high for exactly the cycle after the trap edge, then returns to 0.
- An unaligned RESET_VECTOR or TRAP_VECTOR is not checked. Configuring one is illegal.
- Latency: the pc update is visible one clock after the advance edge. pc_plus_inc has zero latency.

Test Plan:
- Reset release with RESET_VECTOR=0, stall=0, fetch_ready=1 -> pc_valid=0 for one cycle, then pc steps 0, 4, 8, 12 on successive edges.
- stall=1 for 3 cycles at pc=0x10 -> pc stays 0x10. redirect=1 with target 0x40 asserted during the stall is ignored. After stall drops with redirect held, the next pc is 0x40.
- redirect=1, target 0x0000_0202, at pc=0x20 -> pc=0x100, epc=0x20, bad_addr=0x202, trap_taken=1 for one cycle, one cycle with pc_valid=0, then pc steps 0x104.
- trap_req=1 and redirect=1 to 0x80 in the same cycle at pc=0x30 -> trap wins: pc=0x100, epc=0x30, bad_addr=0.
- pc=0xFFFF_FFFC with advance=1 -> pc=0x0000_0000; fetch_ready=0 for 2 cycles -> pc holds.
- Assert reset=0 mid-run between clock edges -> pc=RESET_VECTOR and pc_valid=0 immediately without a clock edge, and the BOOT bubble repeats after release.
